// File: rtl/irig_frame_decoder.sv
// ---------------------------------------------------------------------------
// irig_frame_decoder
//
// Recovers IRIG-style time-code frames from a stream of pre-classified pulse
// symbols. The decoder hunts for two consecutive position markers (the last
// marker of one frame followed by the reference marker of the next). It then
// walks the frame one position at a time and checks each marker slot. It
// collects data bits into a shadow register and publishes the whole frame on
// the final marker.
//
// Parameters
//   FRAME_LEN  symbols per frame, markers included
//   MARK_GAP   marker spacing; positions k*MARK_GAP-1 are markers
//   TIMEOUT    enabled idle cycles tolerated between symbols while synced
//   DATA_W     derived width of frame_data
//
// Ports
//   clk          rising-edge clock
//   hrd_rst_n    synchronous active-low reset
//   ce           clock enable; no state advances while low
//   resync       forces a quiet return to HUNT
//   sym_valid    one-cycle strobe qualifying sym
//   sym          3'b111 MARK, 3'b011 ONE, 3'b001 ZERO, others INVALID
//   frame_data   last complete frame; bit 0 is the first data bit after the
//                reference marker
//   frame_valid  one-cycle pulse when frame_data is updated
//   sync_lost    one-cycle pulse on a sequence error or timeout
//   in_frame     high while walking a frame
//   err_count    saturating count of sync losses
//   state        HUNT=0, ARM=1, FRAME=2
// ---------------------------------------------------------------------------
module irig_frame_decoder #(
  parameter int FRAME_LEN = 100,
  parameter int MARK_GAP  = 10,
  parameter int TIMEOUT   = 1000,
  localparam int DATA_W   = FRAME_LEN - FRAME_LEN / MARK_GAP
) (
  input  logic              clk,
  input  logic              hrd_rst_n,
  input  logic              ce,
  input  logic              resync,
  input  logic              sym_valid,
  input  logic [2:0]        sym,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_valid,
  output logic              sync_lost,
  output logic              in_frame,
  output logic [7:0]        err_count,
  output logic [1:0]        state
);

  localparam int POS_W = $clog2(FRAME_LEN);
  localparam int IDX_W = $clog2(DATA_W);
  localparam int TMR_W = 16;

  localparam logic [2:0] SYM_MARK = 3'b111;
  localparam logic [2:0] SYM_ONE  = 3'b011;
  localparam logic [2:0] SYM_ZERO = 3'b001;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_ARM   = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  state_t              state_q;
  logic [POS_W-1:0]    pos_q;
  logic [IDX_W-1:0]    idx_q;
  logic [TMR_W-1:0]    timer_q;
  logic [DATA_W-1:0]   shadow_q;
  logic [DATA_W-1:0]   frame_data_q;
  logic                frame_valid_q;
  logic                sync_lost_q;
  logic [7:0]          err_count_q;

  logic is_mark;
  logic is_data;
  logic mark_slot;
  logic final_slot;
  logic timeout_hit;
  logic fault;

  // Classification of the current symbol against the current frame position.
  // A symbol arriving in the same cycle as the timer limit suppresses the
  // timeout, so timeout_hit is only raised on symbol-free cycles.
  always_comb begin
    is_mark     = (sym == SYM_MARK);
    is_data     = (sym == SYM_ONE) || (sym == SYM_ZERO);
    mark_slot   = (((32'(pos_q) + 32'd1) % 32'(MARK_GAP)) == 32'd0);
    final_slot  = (32'(pos_q) == 32'(FRAME_LEN - 1));
    timeout_hit = (state_q != ST_HUNT) && !sym_valid &&
                  (32'(timer_q) == 32'(TIMEOUT - 1));
    fault       = 1'b0;
    if (state_q == ST_FRAME && sym_valid) begin
      if (final_slot || mark_slot) fault = !is_mark;
      else                         fault = !is_data;
    end
    if (timeout_hit) fault = 1'b1;
  end

  // Frame-walking FSM. The shadow register is cleared on every frame start,
  // so a frame that aborts part-way can never leak into frame_data.
  // With the usual layout (reference marker at 0 plus markers at every
  // k*MARK_GAP-1) there is one fewer data slot than DATA_W, so the top
  // frame_data bit is never written and reads back 0.
  always_ff @(posedge clk) begin
    if (!hrd_rst_n) begin
      state_q       <= ST_HUNT;
      pos_q         <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_lost_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_lost_q   <= 1'b0;
      if (ce) begin
        if (resync) begin
          state_q <= ST_HUNT;
          pos_q   <= '0;
          idx_q   <= '0;
          timer_q <= '0;
        end else if (fault) begin
          state_q     <= ST_HUNT;
          pos_q       <= '0;
          idx_q       <= '0;
          timer_q     <= '0;
          sync_lost_q <= 1'b1;
          if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end else begin
          case (state_q)
            ST_HUNT: begin
              timer_q <= '0;
              if (sym_valid && is_mark) state_q <= ST_ARM;
            end
            ST_ARM: begin
              if (sym_valid) begin
                timer_q <= '0;
                if (is_mark) begin
                  // The accepted marker is position 0 of the new frame.
                  state_q  <= ST_FRAME;
                  pos_q    <= POS_W'(1);
                  idx_q    <= '0;
                  shadow_q <= '0;
                end else begin
                  state_q <= ST_HUNT;
                end
              end else begin
                timer_q <= timer_q + TMR_W'(1);
              end
            end
            ST_FRAME: begin
              if (sym_valid) begin
                timer_q <= '0;
                if (final_slot) begin
                  // The closing marker doubles as the lead-in for the next
                  // frame, so fall back to ARM rather than HUNT.
                  frame_data_q  <= shadow_q;
                  frame_valid_q <= 1'b1;
                  state_q       <= ST_ARM;
                  pos_q         <= '0;
                  idx_q         <= '0;
                end else if (mark_slot) begin
                  pos_q <= pos_q + POS_W'(1);
                end else begin
                  shadow_q[idx_q] <= (sym == SYM_ONE);
                  idx_q           <= idx_q + IDX_W'(1);
                  pos_q           <= pos_q + POS_W'(1);
                end
              end else begin
                timer_q <= timer_q + TMR_W'(1);
              end
            end
            default: begin
              state_q <= ST_HUNT;
              pos_q   <= '0;
              idx_q   <= '0;
              timer_q <= '0;
            end
          endcase
        end
      end
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_lost   = sync_lost_q;
  assign in_frame    = (state_q == ST_FRAME);
  assign err_count   = err_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_irig_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_irig_frame_decoder
//
// Scenario bench for irig_frame_decoder (FRAME_LEN=100, MARK_GAP=10,
// TIMEOUT=8). Expected frames are derived from the list of data bits placed
// in the non-marker positions; expected error counts and held frame data are
// tracked by the bench as each scenario unfolds.
// ---------------------------------------------------------------------------
module tb_irig_frame_decoder;

  localparam int FL = 100;
  localparam int MG = 10;
  localparam int TO = 8;
  localparam int DW = FL - FL / MG;

  localparam logic [2:0] MARK = 3'b111;
  localparam logic [2:0] ONE  = 3'b011;
  localparam logic [2:0] ZERO = 3'b001;

  logic          clk;
  logic          hrd_rst_n;
  logic          ce;
  logic          resync;
  logic          sym_valid;
  logic [2:0]    sym;
  logic [DW-1:0] fd;
  logic          fv;
  logic          sl;
  logic          inf;
  logic [7:0]    errc;
  logic [1:0]    st;

  int            errors;
  int            checks;
  int            exp_err;
  logic [DW-1:0] exp_fd;

  irig_frame_decoder #(
    .FRAME_LEN (FL),
    .MARK_GAP  (MG),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .hrd_rst_n   (hrd_rst_n),
    .ce          (ce),
    .resync      (resync),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .frame_data  (fd),
    .frame_valid (fv),
    .sync_lost   (sl),
    .in_frame    (inf),
    .err_count   (errc),
    .state       (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Symbol expected at frame position p (1..FL-1) carrying data word bits.
  function automatic logic [2:0] good_sym(input int p, input logic [DW-1:0] bits);
    if (p % MG == MG - 1) return MARK;
    return bits[p - 1 - p / MG] ? ONE : ZERO;
  endfunction

  // Frame word that results from the data bits in order of the data slots.
  function automatic logic [DW-1:0] exp_frame(input logic [DW-1:0] bits);
    logic [DW-1:0] r;
    int n;
    r = '0;
    n = 0;
    for (int p = 1; p < FL; p++) begin
      if (p % MG != MG - 1) begin
        r[n] = bits[n];
        n++;
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_bits();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  task automatic idle(input logic c);
    ce = c; resync = 1'b0; sym_valid = 1'b0;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  // Present one symbol; with jitter, precede it by ignored ce=0 strobes and a
  // few short enabled idle cycles (well under the timeout).
  task automatic send(input logic [2:0] s, input bit jitter);
    int n;
    if (jitter) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        ce = 1'b0; resync = 1'b0; sym_valid = 1'b1; sym = 3'($urandom);
        @(posedge clk); #1;
      end
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) idle(1'b1);
    end
    ce = 1'b1; resync = 1'b0; sym_valid = 1'b1; sym = s;
    @(posedge clk); #1;
    ce = 1'b0; sym_valid = 1'b0;
  endtask

  // Send positions from_p..to_p correctly; count cycles where the decoder
  // left FRAME or raised a pulse while still mid-frame.
  task automatic feed(input logic [DW-1:0] bits, input int from_p, input int to_p,
                      output int glitches);
    glitches = 0;
    for (int p = from_p; p <= to_p; p++) begin
      send(good_sym(p, bits), 1'b1);
      if (fv !== 1'b0 || sl !== 1'b0 || st !== 2'd2) glitches++;
    end
  endtask

  task automatic test_reset();
    hrd_rst_n = 1'b0; ce = 1'b1; resync = 1'b1; sym_valid = 1'b1; sym = MARK;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st); end
    checks++; if (fd !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", fd); end
    checks++; if (fv !== 1'b0 || sl !== 1'b0 || inf !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got fv=%b sl=%b inf=%b want 0 0 0", fv, sl, inf); end
    checks++; if (errc !== 8'd0) begin errors++; $display("FAIL reset_errc: got %0d want 0", errc); end
    hrd_rst_n = 1'b1; ce = 1'b0; resync = 1'b0; sym_valid = 1'b0; sym = 3'b000;
    idle(1'b1);
  endtask

  task automatic test_alternating();
    logic [DW-1:0] bits;
    int g;
    for (int i = 0; i < DW; i++) bits[i] = (i % 2 == 0);
    send(MARK, 1'b0);
    checks++; if (st !== 2'd1 || inf !== 1'b0) begin
      errors++; $display("FAIL alt_arm: got st=%0d inf=%b want 1 0", st, inf); end
    send(MARK, 1'b0);
    checks++; if (st !== 2'd2 || inf !== 1'b1) begin
      errors++; $display("FAIL alt_frame: got st=%0d inf=%b want 2 1", st, inf); end
    feed(bits, 1, FL - 2, g);
    checks++; if (g !== 0) begin errors++; $display("FAIL alt_body: got %0d glitches want 0", g); end
    send(MARK, 1'b0);
    checks++; if (fv !== 1'b1) begin errors++; $display("FAIL alt_fv: got %b want 1", fv); end
    checks++; if (fd !== 90'h1_5555_5555_5555_5555_5555_55) begin
      errors++; $display("FAIL alt_data: got %h want 15555555555555555555555", fd); end
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL alt_end_state: got %0d want 1", st); end
    exp_fd = exp_frame(bits);
    idle(1'b0);
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL alt_fv_width: got %b want 0", fv); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] bits;
    int g;
    int pulses;
    bit hunt_seen;
    pulses = 0;
    hunt_seen = 1'b0;
    for (int f = 0; f < 2; f++) begin
      bits = rand_bits();
      send(MARK, 1'b1);
      if (st === 2'd0) hunt_seen = 1'b1;
      feed(bits, 1, FL - 2, g);
      checks++; if (g !== 0) begin errors++; $display("FAIL b2b_body%0d: got %0d glitches want 0", f, g); end
      send(MARK, 1'b1);
      if (fv === 1'b1) pulses++;
      if (st === 2'd0) hunt_seen = 1'b1;
      exp_fd = exp_frame(bits);
      checks++; if (fd !== exp_fd) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", f, fd, exp_fd); end
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++; if (hunt_seen !== 1'b0) begin errors++; $display("FAIL b2b_hunt: got %b want 0", hunt_seen); end
  endtask

  task automatic test_error_pos19();
    logic [DW-1:0] bits;
    int g;
    bits = rand_bits();
    send(MARK, 1'b0);
    feed(bits, 1, 18, g);
    checks++; if (g !== 0) begin errors++; $display("FAIL pos19_body: got %0d glitches want 0", g); end
    send(ZERO, 1'b0);
    exp_err++;
    checks++; if (sl !== 1'b1) begin errors++; $display("FAIL pos19_sl: got %b want 1", sl); end
    checks++; if (errc !== 8'(exp_err)) begin errors++; $display("FAIL pos19_errc: got %0d want %0d", errc, exp_err); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL pos19_state: got %0d want 0", st); end
    checks++; if (fd !== exp_fd || fv !== 1'b0) begin
      errors++; $display("FAIL pos19_data: got %h fv=%b want %h fv=0", fd, fv, exp_fd); end
    idle(1'b0);
    checks++; if (sl !== 1'b0) begin errors++; $display("FAIL pos19_sl_width: got %b want 0", sl); end
  endtask

  task automatic test_random_errors();
    logic [DW-1:0] bits;
    logic [2:0] bad;
    int g;
    int p;
    bit mslot;
    for (int it = 0; it < 8; it++) begin
      bits = rand_bits();
      p = $urandom_range(1, FL - 1);
      mslot = (p % MG == MG - 1);
      do bad = 3'($urandom);
      while (mslot ? (bad == MARK) : (bad == ONE || bad == ZERO));
      send(MARK, 1'b1);
      send(MARK, 1'b1);
      feed(bits, 1, p - 1, g);
      checks++; if (g !== 0) begin errors++; $display("FAIL rnd%0d_body: got %0d glitches want 0", it, g); end
      send(bad, 1'b1);
      exp_err++;
      checks++; if (sl !== 1'b1 || st !== 2'd0 || errc !== 8'(exp_err) || fd !== exp_fd) begin
        errors++;
        $display("FAIL rnd%0d_err (pos %0d sym %b): got sl=%b st=%0d errc=%0d fd=%h want 1 0 %0d %h",
                 it, p, bad, sl, st, errc, fd, exp_err, exp_fd);
      end
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] bits;
    bits = rand_bits();
    send(MARK, 1'b0);
    send(MARK, 1'b0);
    for (int i = 0; i < TO - 1; i++) idle(1'b1);
    checks++; if (st !== 2'd2 || sl !== 1'b0) begin
      errors++; $display("FAIL to_early: got st=%0d sl=%b want 2 0", st, sl); end
    idle(1'b1);
    exp_err++;
    checks++; if (sl !== 1'b1 || st !== 2'd0) begin
      errors++; $display("FAIL to_fire: got sl=%b st=%0d want 1 0", sl, st); end
    checks++; if (errc !== 8'(exp_err)) begin errors++; $display("FAIL to_errc: got %0d want %0d", errc, exp_err); end
    send(MARK, 1'b0);
    send(MARK, 1'b0);
    for (int i = 0; i < TO - 1; i++) idle(1'b1);
    send(good_sym(1, bits), 1'b0);
    checks++; if (sl !== 1'b0 || st !== 2'd2 || errc !== 8'(exp_err)) begin
      errors++; $display("FAIL to_rescued: got sl=%b st=%0d errc=%0d want 0 2 %0d", sl, st, errc, exp_err); end
    for (int i = 0; i < TO - 1; i++) idle(1'b1);
    for (int i = 0; i < 5; i++) idle(1'b0);
    checks++; if (sl !== 1'b0 || st !== 2'd2) begin
      errors++; $display("FAIL to_ce_gated: got sl=%b st=%0d want 0 2", sl, st); end
  endtask

  task automatic test_ce_resync();
    logic [DW-1:0] bits;
    int g;
    ce = 1'b1; resync = 1'b1; sym_valid = 1'b1; sym = MARK;
    @(posedge clk); #1;
    ce = 1'b0; resync = 1'b0; sym_valid = 1'b0;
    checks++; if (st !== 2'd0 || sl !== 1'b0 || errc !== 8'(exp_err)) begin
      errors++; $display("FAIL rs_first: got st=%0d sl=%b errc=%0d want 0 0 %0d", st, sl, errc, exp_err); end
    bits = rand_bits();
    send(MARK, 1'b0);
    send(MARK, 1'b0);
    feed(bits, 1, 40, g);
    for (int i = 0; i < 6; i++) begin
      ce = 1'b0; sym_valid = 1'b1; sym = 3'($urandom);
      @(posedge clk); #1;
    end
    sym_valid = 1'b0;
    checks++; if (st !== 2'd2 || sl !== 1'b0 || errc !== 8'(exp_err)) begin
      errors++; $display("FAIL ce0_hold: got st=%0d sl=%b errc=%0d want 2 0 %0d", st, sl, errc, exp_err); end
    feed(bits, 41, FL - 2, g);
    send(MARK, 1'b0);
    exp_fd = exp_frame(bits);
    checks++; if (fv !== 1'b1 || fd !== exp_fd) begin
      errors++; $display("FAIL ce0_frame: got fv=%b fd=%h want 1 %h", fv, fd, exp_fd); end
    bits = rand_bits();
    send(MARK, 1'b0);
    feed(bits, 1, 30, g);
    ce = 1'b1; resync = 1'b1; sym_valid = 1'b1; sym = good_sym(31, bits);
    @(posedge clk); #1;
    ce = 1'b0; resync = 1'b0; sym_valid = 1'b0;
    checks++; if (st !== 2'd0 || inf !== 1'b0 || sl !== 1'b0) begin
      errors++; $display("FAIL rs_mid: got st=%0d inf=%b sl=%b want 0 0 0", st, inf, sl); end
    checks++; if (errc !== 8'(exp_err) || fd !== exp_fd) begin
      errors++; $display("FAIL rs_keep: got errc=%0d fd=%h want %0d %h", errc, fd, exp_err, exp_fd); end
  endtask

  task automatic test_err_saturation();
    logic [DW-1:0] bits;
    int g;
    for (int i = 0; i < 256; i++) begin
      send(MARK, 1'b0);
      send(MARK, 1'b0);
      send(3'b000, 1'b0);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      checks++; if (errc !== 8'(exp_err) || sl !== 1'b1) begin
        errors++; $display("FAIL sat%0d: got errc=%0d sl=%b want %0d 1", i, errc, sl, exp_err); end
    end
    bits = rand_bits();
    send(MARK, 1'b0);
    send(MARK, 1'b0);
    feed(bits, 1, 50, g);
    hrd_rst_n = 1'b0; ce = 1'b1; resync = 1'b0; sym_valid = 1'b1; sym = good_sym(51, bits);
    @(posedge clk); #1;
    hrd_rst_n = 1'b1; ce = 1'b0; sym_valid = 1'b0;
    exp_err = 0;
    exp_fd = '0;
    checks++; if (st !== 2'd0 || fd !== '0 || fv !== 1'b0 || sl !== 1'b0 || inf !== 1'b0 || errc !== 8'd0) begin
      errors++;
      $display("FAIL midrst: got st=%0d fd=%h fv=%b sl=%b inf=%b errc=%0d want all 0", st, fd, fv, sl, inf, errc);
    end
    idle(1'b1);
    checks++; if (sl !== 1'b0 || fv !== 1'b0) begin
      errors++; $display("FAIL midrst_after: got sl=%b fv=%b want 0 0", sl, fv); end
    bits = rand_bits();
    send(MARK, 1'b1);
    send(MARK, 1'b1);
    feed(bits, 1, FL - 2, g);
    send(MARK, 1'b1);
    exp_fd = exp_frame(bits);
    checks++; if (fv !== 1'b1 || fd !== exp_fd) begin
      errors++; $display("FAIL post_rst_frame: got fv=%b fd=%h want 1 %h", fv, fd, exp_fd); end
  endtask

  initial begin
    hrd_rst_n = 1'b0; ce = 1'b0; resync = 1'b0; sym_valid = 1'b0; sym = 3'b000;
    errors = 0; checks = 0; exp_err = 0; exp_fd = '0;
    test_reset();
    test_alternating();
    test_back_to_back();
    test_error_pos19();
    test_random_errors();
    test_timeout();
    test_ce_resync();
    test_err_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
